// File: rtl/wb_pkg.sv
// Shared types and default source indices for the writeback mux stage.
package wb_pkg;

    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10
    } ld_size_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_e;

    localparam int SRC_ALU = 0;
    localparam int SRC_RAM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_IMM = 3;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: picks the byte/halfword lane of a loaded word
// and sign- or zero-extends it to the datapath width.
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [1:0]        addr_lo_i,
    output logic [DATA_W-1:0] data_o
);

    logic [31:0]        word_v;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    assign word_v = data_i[31:0];

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_v = word_v[7:0];
            2'd1:    byte_v = word_v[15:8];
            2'd2:    byte_v = word_v[23:16];
            default: byte_v = word_v[31:24];
        endcase
        // Halfword lane ignores addr_lo[0]; misaligned halves fall back to the aligned lane.
        half_v = addr_lo_i[1] ? word_v[31:16] : word_v[15:0];
        byte_s = signed'(byte_v);
        half_s = signed'(half_v);
        word_s = signed'(word_v);

        data_o = '0;
        case (size_i)
            LD_BYTE: begin
                if (sign_i) data_o = DATA_W'(byte_s);
                else        data_o = DATA_W'(byte_v);
            end
            LD_HALF: begin
                if (sign_i) data_o = DATA_W'(half_s);
                else        data_o = DATA_W'(half_v);
            end
            default: begin
                if (sign_i) data_o = DATA_W'(word_s);
                else        data_o = DATA_W'(word_v);
            end
        endcase
    end

endmodule

// File: rtl/wb_mux_stage.sv
// Writeback stage: source select + load formatting into a 2-entry skid buffer.
// Define WB_MUX_FWD_EN to expose head/skid entries on fwd_*/fwd2_* bypass ports.
module wb_mux_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int REG_AW   = 4,
    parameter int LOAD_SRC = SRC_RAM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic [1:0]                in_ld_size,
    input  logic                      in_ld_signed,
    input  logic [1:0]                in_addr_lo,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [REG_AW-1:0]         out_rd
`ifdef WB_MUX_FWD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_AW-1:0]         fwd_rd,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      fwd2_valid,
    output logic [REG_AW-1:0]         fwd2_rd,
    output logic [DATA_W-1:0]         fwd2_data
`endif
);

    occ_e              state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [REG_AW-1:0] head_rd_q, head_rd_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] new_data;
    logic              accept;
    logic              retire;

    wb_load_fmt #(
        .DATA_W(DATA_W)
    ) u_load_fmt (
        .data_i   (in_src_data[LOAD_SRC*DATA_W +: DATA_W]),
        .size_i   (in_ld_size),
        .sign_i   (in_ld_signed),
        .addr_lo_i(in_addr_lo),
        .data_o   (load_data)
    );

    // Out-of-range selects match no source and leave the data at zero.
    always_comb begin
        new_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(in_sel) == k) begin
                if (k == LOAD_SRC) new_data = load_data;
                else               new_data = in_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign retire    = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d     = OCC_ONE;
                    head_data_d = new_data;
                    head_rd_d   = in_rd;
                end
            end
            OCC_ONE: begin
                if (accept && !retire) begin
                    state_d     = OCC_TWO;
                    skid_data_d = new_data;
                    skid_rd_d   = in_rd;
                end else if (accept && retire) begin
                    head_data_d = new_data;
                    head_rd_d   = in_rd;
                end else if (retire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (retire) begin
                    state_d     = OCC_ONE;
                    head_data_d = skid_data_q;
                    head_rd_d   = skid_rd_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_rd_q   <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != OCC_TWO);
            head_data_q <= head_data_d;
            head_rd_q   <= head_rd_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

    assign out_data = head_data_q;
    assign out_rd   = head_rd_q;

`ifdef WB_MUX_FWD_EN
    assign fwd_valid  = out_valid;
    assign fwd_rd     = head_rd_q;
    assign fwd_data   = head_data_q;
    assign fwd2_valid = (state_q == OCC_TWO);
    assign fwd2_rd    = skid_rd_q;
    assign fwd2_data  = skid_data_q;
`endif

endmodule

// File: tb/tb_wb_mux_stage.sv
// Self-checking bench for wb_mux_stage against a 2-deep FIFO reference model.
module tb_wb_mux_stage;

    localparam int DATA_W   = 32;
    localparam int NUM_SRC  = 4;
    localparam int SEL_W    = 3;
    localparam int REG_AW   = 4;
    localparam int LOAD_SRC = 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel = '0;
    logic [NUM_SRC*DATA_W-1:0] in_src_data = '0;
    logic [REG_AW-1:0]         in_rd = '0;
    logic [1:0]                in_ld_size = '0;
    logic                      in_ld_signed = 1'b0;
    logic [1:0]                in_addr_lo = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [DATA_W-1:0]         out_data;
    logic [REG_AW-1:0]         out_rd;
`ifdef WB_MUX_FWD_EN
    logic                      fwd_valid, fwd2_valid;
    logic [REG_AW-1:0]         fwd_rd, fwd2_rd;
    logic [DATA_W-1:0]         fwd_data, fwd2_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] ret_log[$];

    always #5 clk = ~clk;

    wb_mux_stage #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_AW(REG_AW), .LOAD_SRC(LOAD_SRC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_src_data(in_src_data),
        .in_rd(in_rd), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_addr_lo(in_addr_lo),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd)
`ifdef WB_MUX_FWD_EN
        ,
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd2_valid(fwd2_valid), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data)
`endif
    );

    // Reference value of a write: arithmetic lane extraction and extension.
    function automatic logic [31:0] ref_value(input logic [2:0] sel, input logic [127:0] srcs,
                                              input logic [1:0] sz, input logic sg, input logic [1:0] al);
        logic [31:0] w;
        longint      v, m;
        int          lane, nbits;
        if (int'(sel) >= NUM_SRC) return 32'h0;
        w = srcs[int'(sel)*32 +: 32];
        if (int'(sel) != LOAD_SRC) return w;
        if (sz == 2'd0) begin
            nbits = 8;
            lane  = int'(al);
        end else if (sz == 2'd1) begin
            nbits = 16;
            lane  = (int'(al) / 2) * 2;
        end else begin
            return w;
        end
        v = longint'(w) >> (lane * 8);
        m = longint'(1) << nbits;
        v = v & (m - 1);
        if (sg && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic logic [127:0] rand_srcs();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_entry(input logic [2:0] sel, input logic [127:0] srcs, input logic [3:0] rd,
                             input logic [1:0] sz, input logic sg, input logic [1:0] al);
        in_valid     = 1'b1;
        in_sel       = sel;
        in_src_data  = srcs;
        in_rd        = rd;
        in_ld_size   = sz;
        in_ld_signed = sg;
        in_addr_lo   = al;
    endtask

    task automatic rand_entry();
        set_entry(3'($urandom_range(0, 5)), rand_srcs(), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    // Advance one clock and update the FIFO model with what the handshakes did.
    task automatic clock_model();
        bit   acc, ret;
        ent_t e;
        acc    = in_valid && in_ready;
        ret    = out_valid && out_ready;
        e.data = ref_value(in_sel, in_src_data, in_ld_size, in_ld_signed, in_addr_lo);
        e.rd   = in_rd;
        if (ret) ret_log.push_back(out_data);
        @(posedge clk);
        #1;
        if (ret && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) clock_model();
    endtask

    task automatic test_reset();
        logic [31:0] c;
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_rd !== 4'h0) begin errors++; $display("FAIL reset_out_rd got %h exp 0", out_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        rand_entry();
        clock_model();
        rand_entry();
        clock_model();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_in_ready got %b exp 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL async_out_data got %h exp 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %b exp 1", in_ready); end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        c = $urandom();
        set_entry(3'd0, {96'h0, c}, 4'd7, 2'd0, 1'b0, 2'd0);
        clock_model();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== c || out_rd !== 4'd7) begin
            errors++; $display("FAIL post_reset_first got v=%b d=%h rd=%h exp v=1 d=%h rd=7", out_valid, out_data, out_rd, c);
        end
        clock_model();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_stale got %b exp 0", out_valid); end
    endtask

    task automatic test_select();
        logic [127:0] s;
        out_ready = 1'b1;
        s = rand_srcs();
        s[31:0] = 32'h0000_1234;
        set_entry(3'd0, s, 4'd5, 2'd0, 1'b0, 2'd0);
        clock_model();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || out_rd !== 4'd5) begin
            errors++; $display("FAIL sel_alu got v=%b d=%h rd=%h exp v=1 d=00001234 rd=5", out_valid, out_data, out_rd);
        end
        set_entry(3'd7, rand_srcs(), 4'd9, 2'd2, 1'b1, 2'd0);
        clock_model();
        checks++; if (out_data !== 32'h0 || out_rd !== 4'd9) begin
            errors++; $display("FAIL sel_out_of_range got d=%h rd=%h exp d=0 rd=9", out_data, out_rd);
        end
        for (int i = 0; i < 24; i++) begin
            rand_entry();
            clock_model();
            checks++;
            if (exp_q.size() == 0 || out_data !== exp_q[0].data || out_rd !== exp_q[0].rd) begin
                errors++; $display("FAIL sel_random[%0d] got d=%h rd=%h exp d=%h rd=%h", i, out_data, out_rd,
                                   exp_q.size() ? exp_q[0].data : 32'hx, exp_q.size() ? exp_q[0].rd : 4'hx);
            end
        end
        drain();
    endtask

    task automatic test_loads();
        logic [1:0]   sz[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic         sg[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]   al[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0]  ex[5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_8081, 32'hFFFF_8081, 32'h8081_7F80};
        logic [127:0] s;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s = rand_srcs();
            s[63:32] = 32'h8081_7F80;
            set_entry(3'd1, s, 4'(i), sz[i], sg[i], al[i]);
            clock_model();
            checks++; if (out_data !== ex[i]) begin
                errors++; $display("FAIL load_table[%0d] got %h exp %h", i, out_data, ex[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            set_entry(3'd1, rand_srcs(), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            clock_model();
            checks++;
            if (exp_q.size() == 0 || out_data !== exp_q[0].data) begin
                errors++; $display("FAIL load_random[%0d] got %h exp %h", i, out_data,
                                   exp_q.size() ? exp_q[0].data : 32'hx);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        bit          took;
        a = $urandom();
        b = a ^ 32'h1;
        c = a ^ 32'h2;
        ret_log.delete();
        out_ready = 1'b0;
        set_entry(3'd0, {96'h0, a}, 4'd1, 2'd0, 1'b0, 2'd0);
        clock_model();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
        set_entry(3'd0, {96'h0, b}, 4'd2, 2'd0, 1'b0, 2'd0);
        clock_model();
        set_entry(3'd0, {96'h0, c}, 4'd3, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a || out_rd !== 4'd1) begin
                errors++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h rd=%h exp rdy=0 v=1 d=%h rd=1",
                                   i, in_ready, out_valid, out_data, out_rd, a);
            end
            clock_model();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            took = in_valid && in_ready;
            clock_model();
            if (took) in_valid = 1'b0;
        end
        checks++; if (ret_log.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d exp 3", ret_log.size());
        end else begin
            checks++; if (ret_log[0] !== a || ret_log[1] !== b || ret_log[2] !== c) begin
                errors++; $display("FAIL bp_order got %h %h %h exp %h %h %h", ret_log[0], ret_log[1], ret_log[2], a, b, c);
            end
        end
        drain();
    endtask

    task automatic test_stream();
        logic [31:0] vals[16];
        drain();
        ret_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom();
            set_entry(3'd0, {rand_srcs() & {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0}} | {96'h0, vals[i]},
                      4'(i), 2'd0, 1'b0, 2'd0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
            clock_model();
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i] || out_rd !== 4'(i)) begin
                errors++; $display("FAIL stream_write[%0d] got v=%b d=%h rd=%h exp v=1 d=%h rd=%h",
                                   i, out_valid, out_data, out_rd, vals[i], 4'(i));
            end
        end
        in_valid = 1'b0;
        clock_model();
        checks++; if (ret_log.size() != 16) begin
            errors++; $display("FAIL stream_count got %0d exp 16", ret_log.size());
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) rand_entry();
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            checks++; if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL rand_ctrl[%0d] got v=%b rdy=%b exp v=%b rdy=%b", i, out_valid, in_ready,
                                   exp_q.size() > 0, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                checks++; if (out_data !== exp_q[0].data || out_rd !== exp_q[0].rd) begin
                    errors++; $display("FAIL rand_data[%0d] got d=%h rd=%h exp d=%h rd=%h", i, out_data, out_rd,
                                       exp_q[0].data, exp_q[0].rd);
                end
            end
            clock_model();
        end
        drain();
    endtask

`ifdef WB_MUX_FWD_EN
    task automatic test_fwd();
        drain();
        out_ready = 1'b0;
        rand_entry();
        clock_model();
        rand_entry();
        clock_model();
        in_valid = 1'b0;
        checks++; if (exp_q.size() != 2 || fwd_valid !== 1'b1 || fwd_rd !== exp_q[0].rd || fwd_data !== exp_q[0].data) begin
            errors++; $display("FAIL fwd_head got v=%b rd=%h d=%h", fwd_valid, fwd_rd, fwd_data);
        end
        checks++; if (exp_q.size() != 2 || fwd2_valid !== 1'b1 || fwd2_rd !== exp_q[1].rd || fwd2_data !== exp_q[1].data) begin
            errors++; $display("FAIL fwd_skid got v=%b rd=%h d=%h", fwd2_valid, fwd2_rd, fwd2_data);
        end
        out_ready = 1'b1;
        clock_model();
        checks++; if (fwd2_valid !== 1'b0 || exp_q.size() != 1 || fwd_data !== exp_q[0].data) begin
            errors++; $display("FAIL fwd_after_retire got v2=%b d=%h", fwd2_valid, fwd_data);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_loads();
        test_backpressure();
        test_stream();
        test_random();
`ifdef WB_MUX_FWD_EN
        test_fwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
